// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between instruction fetch (read only) and data load/store.
// Data side wins by default; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  state_dbg,
    output logic [3:0]  starve_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic       owner;
    logic [3:0] starve;
    logic       grant_data, grant_inst;
    logic       addr_hs, data_hs;

    always_comb begin
        state_nxt  = state;
        grant_data = 1'b0;
        grant_inst = 1'b0;
        case (state)
            IDLE: begin
                if (data_req && (starve < LIMIT)) grant_data = 1'b1;
                else if (inst_req)                grant_inst = 1'b1;
                else if (data_req)                grant_data = 1'b1;
                if (grant_data || grant_inst) state_nxt = ADDR;
            end
            ADDR:    if (bus_addr_ok) state_nxt = WAIT;
            WAIT:    if (bus_data_ok) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b0;
            starve    <= 4'd0;
            bus_req   <= 1'b0;
            bus_wr    <= 1'b0;
            bus_size  <= 2'd0;
            bus_addr  <= 32'd0;
            bus_wstrb <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (grant_inst) begin
                owner     <= 1'b0;
                starve    <= 4'd0;
                bus_req   <= 1'b1;
                bus_wr    <= 1'b0;
                bus_size  <= 2'd2;
                bus_addr  <= inst_addr;
                bus_wstrb <= 4'd0;
                bus_wdata <= 32'd0;
            end else if (grant_data) begin
                owner     <= 1'b1;
                bus_req   <= 1'b1;
                bus_wr    <= data_wr;
                bus_size  <= data_size;
                bus_addr  <= data_addr;
                bus_wstrb <= data_wstrb;
                bus_wdata <= data_wdata;
                // Only data grants taken over a waiting fetch count toward starvation.
                if (!inst_req)           starve <= 4'd0;
                else if (starve < LIMIT) starve <= starve + 4'd1;
            end else if (addr_hs) begin
                bus_req <= 1'b0;
            end
        end
    end

    assign addr_hs = (state == ADDR) && bus_addr_ok;
    assign data_hs = (state == WAIT) && bus_data_ok;

    assign inst_addr_ok = addr_hs && !owner;
    assign data_addr_ok = addr_hs &&  owner;
    assign inst_data_ok = data_hs && !owner;
    assign data_data_ok = data_hs &&  owner;
    assign inst_rdata   = inst_data_ok ? bus_rdata : 32'd0;
    assign data_rdata   = data_data_ok ? bus_rdata : 32'd0;

    assign state_dbg  = state;
    assign starve_cnt = starve;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: the bench plays the bus bridge, pushes the read data it
// will return into exp_q on address acceptance, and pops it when the owner's data_ok pulses.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok, bus_data_ok;
    logic [31:0] bus_rdata;
    logic [1:0]  state_dbg;
    logic [3:0]  starve_cnt;

    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
        .state_dbg(state_dbg), .starve_cnt(starve_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus-bridge driver. Entered in the first ADDR cycle; returns in the following IDLE cycle.
    task automatic serve(input logic owner, input int addr_wait, input int data_wait,
                         input logic [31:0] rd, input logic drop, input logic toggle,
                         input logic e_wr, input logic [1:0] e_size, input logic [31:0] e_addr,
                         input logic [3:0] e_wstrb, input logic [31:0] e_wdata);
        logic [31:0] got;
        for (int i = 0; i < addr_wait; i++) begin
            if (toggle) begin
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            #1;
            chk("stall_bus_req", bus_req, 1'b1);
            chk("stall_bus_addr", bus_addr, e_addr);
            chk("stall_bus_wdata", bus_wdata, e_wdata);
            chk("stall_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
            tick();
        end
        bus_addr_ok = 1'b1;
        #1;
        chk("grant_owner_addr_ok", owner ? data_addr_ok : inst_addr_ok, 1'b1);
        chk("grant_other_addr_ok", owner ? inst_addr_ok : data_addr_ok, 1'b0);
        chk("bus_req", bus_req, 1'b1);
        chk("bus_wr", bus_wr, e_wr);
        chk("bus_size", bus_size, e_size);
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wstrb", bus_wstrb, e_wstrb);
        chk("bus_wdata", bus_wdata, e_wdata);
        exp_q.push_back(rd);
        tick();
        bus_addr_ok = 1'b0;
        if (drop) begin
            if (owner) data_req = 1'b0;
            else       inst_req = 1'b0;
        end
        for (int i = 0; i < data_wait; i++) begin
            #1;
            chk("wait_state", state_dbg, 2'd2);
            chk("wait_bus_req", bus_req, 1'b0);
            chk("wait_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
            tick();
        end
        bus_data_ok = 1'b1;
        bus_rdata   = rd;
        #1;
        chk("owner_data_ok", owner ? data_data_ok : inst_data_ok, 1'b1);
        chk("other_data_ok", owner ? inst_data_ok : data_data_ok, 1'b0);
        chk("other_rdata", owner ? inst_rdata : data_rdata, 32'd0);
        got = owner ? data_rdata : inst_rdata;
        if (exp_q.size() == 0) chk("exp_q_underflow", 32'd0, 32'd1);
        else                   chk("owner_rdata", got, exp_q.pop_front());
        tick();
        bus_data_ok = 1'b0;
        bus_rdata   = 32'd0;
    endtask

    logic pat[10]     = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    logic [3:0] sc[10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic [31:0] rd_v;

    initial begin
        rst = 1'b1; inst_req = 1'b0; inst_addr = 32'd0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0;
        data_wstrb = 4'd0; data_wdata = 32'd0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;
        tick(); tick();
        #1;
        chk("rst_state", state_dbg, 2'd0);
        chk("rst_starve", starve_cnt, 4'd0);
        chk("rst_bus", {bus_req, bus_wr, bus_size, bus_wstrb}, 8'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0000);
        tick();
        rst = 1'b0;

        // single fetch
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
        #1;
        chk("fetch_idle_state", state_dbg, 2'd0);
        tick();
        serve(1'b0, 0, 1, 32'h3C1D_0001, 1'b1, 1'b0, 1'b0, 2'd2, 32'hBFC0_0000, 4'd0, 32'd0);
        #1;
        chk("fetch_back_idle", state_dbg, 2'd0);
        chk("fetch_no_req", bus_req, 1'b0);

        // store byte
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_addr = 32'h8000_0003;
        data_wstrb = 4'b1000; data_wdata = 32'hAB00_0000;
        tick();
        serve(1'b1, 0, 0, 32'h0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h8000_0003, 4'b1000, 32'hAB00_0000);
        #1;
        chk("store_quiet", {inst_addr_ok, inst_data_ok, data_data_ok}, 3'b000);

        // simultaneous: data first, then fetch
        inst_req = 1'b1; inst_addr = 32'h0000_1000;
        data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_2000;
        data_wstrb = 4'd0; data_wdata = 32'd0;
        tick();
        chk("simul_starve_1", starve_cnt, 4'd1);
        serve(1'b1, 1, 0, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_2000, 4'd0, 32'd0);
        tick();
        chk("simul_starve_0", starve_cnt, 4'd0);
        serve(1'b0, 0, 2, 32'h3333_4444, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_1000, 4'd0, 32'd0);

        // starvation limit with both requesters held
        inst_req = 1'b1; data_req = 1'b1; data_addr = 32'h0000_3000;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("starve_cnt", starve_cnt, sc[i]);
            rd_v = $urandom;
            if (pat[i])
                serve(1'b1, $urandom_range(0, 2), $urandom_range(0, 2), rd_v, 1'b0, 1'b0,
                      1'b0, 2'd2, 32'h0000_3000, 4'd0, 32'd0);
            else
                serve(1'b0, $urandom_range(0, 2), $urandom_range(0, 2), rd_v, 1'b0, 1'b0,
                      1'b0, 2'd2, 32'h0000_1000, 4'd0, 32'd0);
        end
        inst_req = 1'b0; data_req = 1'b0;
        tick();
        #1;
        chk("starve_idle", state_dbg, 2'd0);

        // slow bus with toggling requester fields
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_addr = 32'h0000_4002;
        data_wstrb = 4'b1100; data_wdata = 32'h5A5A_0000;
        tick();
        serve(1'b1, 5, 1, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'h0000_4002, 4'b1100, 32'h5A5A_0000);

        // reset while in WAIT
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_5000; inst_req = 1'b1;
        tick();
        chk("rw_starve_pre", starve_cnt, 4'd1);
        bus_addr_ok = 1'b1;
        #1;
        chk("rw_addr_ok", data_addr_ok, 1'b1);
        tick();
        bus_addr_ok = 1'b0; data_req = 1'b0; inst_req = 1'b0; rst = 1'b1;
        #1;
        chk("rw_in_wait", state_dbg, 2'd2);
        tick();
        rst = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rw_state", state_dbg, 2'd0);
        chk("rw_bus_req", bus_req, 1'b0);
        chk("rw_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
        chk("rw_starve", starve_cnt, 4'd0);
        tick();
        bus_data_ok = 1'b0; bus_rdata = 32'd0;
        #1;
        chk("rw_still_idle", state_dbg, 2'd0);

        chk("exp_q_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
